instr_fetch_unit: RTL

//  Decoupled RV32I instruction fetch stage that sits upstream of the core's decode/control path.

---
 rtl/rv32_pkg.sv | 16 +
 rtl/instr_fetch_unit_sync_fifo.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 76 +++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-side types: instruction/address widths and the packet
// that the prefetch buffer carries toward decode.
package rv32_pkg;
  localparam int XLEN        = 32;
  localparam int ILEN        = 32;
  localparam int INSTR_ALIGN = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch_unit_sync_fifo.sv
// In-order prefetch buffer with flush; head is presented from storage and
// zeroed while empty so nothing stale leaks toward decode.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: the read side is gated by count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled RV32 fetch: credit-limited word requests, in-order response
// buffering with PCs, and redirect flush that drops responses still in flight.
module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [CW-1:0]   count, inflight, discard;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_live, push, pop;
  fetch_pkt_t      wr_pkt, rd_pkt;

  assign credit_used    = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response belongs to the live stream only once all pre-redirect words have drained.
  assign rsp_live = imem_rsp_valid && (discard == '0);
  assign push     = rsp_live && !redirect_valid;
  assign pop      = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
      resp_pc  <= align_pc(redirect_pc);
      inflight <= '0;
      discard  <= discard + inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_ALIGN);
      if (push)     resp_pc  <= resp_pc + XLEN'(INSTR_ALIGN);
      inflight <= inflight + CW'(req_fire) - CW'(rsp_live);
      if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  assign wr_pkt = '{pc: resp_pc, instr: imem_rsp_data};

  sync_fifo #(.WIDTH($bits(fetch_pkt_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_pkt),
    .rdata (rd_pkt),
    .count (count)
  );

  assign instr_valid = (count != '0);
  assign instr_data  = rd_pkt.instr;
  assign instr_pc    = rd_pkt.pc;
endmodule
